// File: rtl/tdm_pkg.sv
// tdm_pkg -- shared definitions for the 4-slot TDM receive demultiplexer.
//   state_t    : FSM encodings (IDLE / DATA / PAR)
//   N_CH       : data slots per frame (fixed at 4 for this revision)
//   SEL_W      : width of the slot index
//   LAST_SLOT  : index of the final data slot
//   parity_of  : expected parity bit for a frame (XNOR-reduce of the data)
package tdm_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(N_CH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_t;

  // Parity slot carries 1 when the data holds an even number of ones.
  function automatic logic parity_of(input logic [N_CH-1:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/tdm_demux4_if.sv
// tdm_demux4_if -- serial-in / parallel-out bundle of the TDM demultiplexer.
//   en, sync_in, din           : serial side, driven by the link (master)
//   dout, dout_valid, frame_err: parallel frame result, driven by the demux
//   sel, busy                  : progress status, driven by the demux
// modport master : the link / consumer side that drives the serial inputs
// modport slave  : the demultiplexer itself
interface tdm_demux4_if;
  import tdm_pkg::*;

  logic             en;
  logic             sync_in;
  logic             din;
  logic [N_CH-1:0]  dout;
  logic             dout_valid;
  logic             frame_err;
  logic [SEL_W-1:0] sel;
  logic             busy;

  modport master (
    output en, sync_in, din,
    input  dout, dout_valid, frame_err, sel, busy
  );

  modport slave (
    input  en, sync_in, din,
    output dout, dout_valid, frame_err, sel, busy
  );

endinterface

// File: rtl/slot_dec2to4.sv
// slot_dec2to4 -- combinational 2-to-4 one-hot decoder with enable.
//   en     : when 0 every output is 0
//   idx    : slot index to decode
//   onehot : bit idx is 1 when en=1, all others 0
module slot_dec2to4
  import tdm_pkg::*;
(
  input  logic             en,
  input  logic [SEL_W-1:0] idx,
  output logic [N_CH-1:0]  onehot
);

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4 -- receive-side 1-to-4 time-division demultiplexer.
// A frame is five strobed slots: four data bits (slot 0 flagged by sync_in)
// followed by one parity bit. A frame with correct parity is presented on
// dout with a one-cycle dout_valid; a parity mismatch or a frame cut short by
// a new sync produces a one-cycle frame_err instead. N_CH is fixed at 4 by
// tdm_pkg.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : tdm_demux4_if.slave
//            en / sync_in / din   serial slot strobe, frame marker, data bit
//            dout / dout_valid    last good frame and its update pulse
//            frame_err            parity mismatch or aborted frame pulse
//            sel                  next data slot expected (0 in IDLE / PAR)
//            busy                 1 while a frame is in progress
module tdm_demux4
  import tdm_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  tdm_demux4_if.slave  bus
);

  state_t           state, state_nx;
  logic [SEL_W-1:0] cnt, cnt_nx;
  logic [N_CH-1:0]  shift;
  logic [N_CH-1:0]  slot_we;
  logic [N_CH-1:0]  dout_q;
  logic             valid_q, err_q, busy_q;
  logic             valid_nx, err_nx;
  logic             start_frame;
  logic             load_dout;

  // Per-slot write enables for the data slots after slot 0. A strobe that
  // carries sync is a frame restart and goes through start_frame instead.
  slot_dec2to4 u_slot_dec (
    .en     (bus.en & ~bus.sync_in & (state == DATA)),
    .idx    (cnt),
    .onehot (slot_we)
  );

  // Next-state and pulse decode.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    start_frame = 1'b0;
    load_dout   = 1'b0;
    valid_nx    = 1'b0;
    err_nx      = 1'b0;

    if (bus.en) begin
      if (bus.sync_in) begin
        // Sync always opens a new frame; outside IDLE it also aborts the
        // frame in progress.
        start_frame = 1'b1;
        state_nx    = DATA;
        cnt_nx      = SEL_W'(1);
        err_nx      = (state != IDLE);
      end else begin
        unique case (state)
          IDLE: ;  // stray bit before any sync is dropped
          DATA: begin
            cnt_nx = cnt + 1'b1;  // wraps to 0 after the last data slot
            if (cnt == LAST_SLOT) state_nx = PAR;
          end
          PAR: begin
            if (bus.din == parity_of(shift)) begin
              load_dout = 1'b1;
              valid_nx  = 1'b1;
            end else begin
              err_nx = 1'b1;
            end
            state_nx = IDLE;
            cnt_nx   = '0;
          end
          default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // NOTE: the slot shift register is reset along with the control state; it
  // is only four flops, and a known value keeps parity checks deterministic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift <= '0;
    end else if (start_frame) begin
      // Discard any partial frame so stale bits never reach dout.
      shift <= {{(N_CH-1){1'b0}}, bus.din};
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (slot_we[i]) shift[i] <= bus.din;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      if (load_dout) dout_q <= shift;
      valid_q <= valid_nx;
      err_q   <= err_nx;
      busy_q  <= (state_nx != IDLE);
    end
  end

  // cnt already sits at 0 in IDLE and PAR, so it doubles as sel.
  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.frame_err  = err_q;
  assign bus.sel        = cnt;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4 -- directed self-checking bench for tdm_demux4.
// Each step is {en, sync_in, din}; after the clock edge the observed vector
// {dout[3:0], dout_valid, frame_err, sel[1:0], busy} is compared with a
// hand-computed expectation.
module tb_tdm_demux4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_passed;

  tdm_demux4_if bus ();

  tdm_demux4 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] obs();
    return {bus.dout, bus.dout_valid, bus.frame_err, bus.sel, bus.busy};
  endfunction

  // One clock cycle: inputs change on the falling edge, outputs are sampled
  // 1 ns after the rising edge. Strobe inputs are dropped again afterwards.
  task automatic step(input logic [2:0] s);
    @(negedge clk);
    bus.en      = s[2];
    bus.sync_in = s[1];
    bus.din     = s[0];
    @(posedge clk);
    #1;
    bus.en      = 1'b0;
    bus.sync_in = 1'b0;
    bus.din     = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    bus.en      = 1'b0;
    bus.sync_in = 1'b0;
    bus.din     = 1'b0;
    #1;
    n_checks++;
    if (obs() !== 9'b0000_0_0_00_0)
      $display("FAIL reset_state got=%b exp=%b", obs(), 9'b0000_0_0_00_0);
    else n_passed++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // 1,0,1,1 has three ones, so the expected parity bit is 0.
  task automatic test_good_frame();
    logic [2:0] stim [6];
    logic [8:0] exp  [6];
    stim = '{3'b111, 3'b100, 3'b101, 3'b101, 3'b100, 3'b000};
    exp  = '{9'b0000_0_0_01_1, 9'b0000_0_0_10_1, 9'b0000_0_0_11_1,
             9'b0000_0_0_00_1, 9'b1101_1_0_00_0, 9'b1101_0_0_00_0};
    for (int i = 0; i < 6; i++) begin
      step(stim[i]);
      n_checks++;
      if (obs() !== exp[i])
        $display("FAIL good_frame[%0d] got=%b exp=%b", i, obs(), exp[i]);
      else n_passed++;
    end
  endtask

  task automatic test_bad_parity();
    logic [2:0] stim [6];
    logic [8:0] exp  [6];
    do_reset();
    stim = '{3'b111, 3'b100, 3'b101, 3'b101, 3'b101, 3'b000};
    exp  = '{9'b0000_0_0_01_1, 9'b0000_0_0_10_1, 9'b0000_0_0_11_1,
             9'b0000_0_0_00_1, 9'b0000_0_1_00_0, 9'b0000_0_0_00_0};
    for (int i = 0; i < 6; i++) begin
      step(stim[i]);
      n_checks++;
      if (obs() !== exp[i])
        $display("FAIL bad_parity[%0d] got=%b exp=%b", i, obs(), exp[i]);
      else n_passed++;
    end
  endtask

  // Frame 0,0,0,0 with parity 1 and three idle cycles after slot 1.
  task automatic test_en_gap();
    logic [2:0] stim [8];
    logic [8:0] exp  [8];
    stim = '{3'b110, 3'b100, 3'b000, 3'b000, 3'b000, 3'b100, 3'b100, 3'b101};
    exp  = '{9'b0000_0_0_01_1, 9'b0000_0_0_10_1, 9'b0000_0_0_10_1,
             9'b0000_0_0_10_1, 9'b0000_0_0_10_1, 9'b0000_0_0_11_1,
             9'b0000_0_0_00_1, 9'b0000_1_0_00_0};
    for (int i = 0; i < 8; i++) begin
      step(stim[i]);
      n_checks++;
      if (obs() !== exp[i])
        $display("FAIL en_gap[%0d] got=%b exp=%b", i, obs(), exp[i]);
      else n_passed++;
    end
  endtask

  // Sync at slot 2 aborts; the restarted frame 0,1,1,0 has even ones -> 1.
  task automatic test_premature_sync();
    logic [2:0] stim [7];
    logic [8:0] exp  [7];
    stim = '{3'b111, 3'b101, 3'b110, 3'b101, 3'b101, 3'b100, 3'b101};
    exp  = '{9'b0000_0_0_01_1, 9'b0000_0_0_10_1, 9'b0000_0_1_01_1,
             9'b0000_0_0_10_1, 9'b0000_0_0_11_1, 9'b0000_0_0_00_1,
             9'b0110_1_0_00_0};
    for (int i = 0; i < 7; i++) begin
      step(stim[i]);
      n_checks++;
      if (obs() !== exp[i])
        $display("FAIL premature_sync[%0d] got=%b exp=%b", i, obs(), exp[i]);
      else n_passed++;
    end
  endtask

  task automatic test_idle_ignore();
    logic [2:0] stim [3];
    stim = '{3'b101, 3'b100, 3'b101};
    for (int i = 0; i < 3; i++) begin
      step(stim[i]);
      n_checks++;
      if (obs() !== 9'b0110_0_0_00_0)
        $display("FAIL idle_ignore[%0d] got=%b exp=%b", i, obs(), 9'b0110_0_0_00_0);
      else n_passed++;
    end
  endtask

  // 1111 (parity 1) then 0001 (parity 0) on consecutive strobes.
  task automatic test_back_to_back();
    logic [2:0] stim [10];
    logic [8:0] exp  [10];
    int         first_v;
    int         last_v;
    int         n_v;
    stim = '{3'b111, 3'b101, 3'b101, 3'b101, 3'b101,
             3'b111, 3'b100, 3'b100, 3'b100, 3'b100};
    exp  = '{9'b0110_0_0_01_1, 9'b0110_0_0_10_1, 9'b0110_0_0_11_1,
             9'b0110_0_0_00_1, 9'b1111_1_0_00_0,
             9'b1111_0_0_01_1, 9'b1111_0_0_10_1, 9'b1111_0_0_11_1,
             9'b1111_0_0_00_1, 9'b0001_1_0_00_0};
    first_v = -1;
    last_v  = -1;
    n_v     = 0;
    for (int i = 0; i < 10; i++) begin
      step(stim[i]);
      if (bus.dout_valid === 1'b1) begin
        if (first_v < 0) first_v = i;
        last_v = i;
        n_v++;
      end
      n_checks++;
      if (obs() !== exp[i])
        $display("FAIL back_to_back[%0d] got=%b exp=%b", i, obs(), exp[i]);
      else n_passed++;
    end
    n_checks++;
    if (n_v !== 2 || (last_v - first_v) !== 5)
      $display("FAIL b2b_spacing got=%0d pulses %0d apart exp=2 pulses 5 apart",
               n_v, last_v - first_v);
    else n_passed++;
  endtask

  task automatic test_reset_mid_frame();
    logic [2:0] stim [5];
    logic [8:0] exp  [5];
    stim = '{3'b110, 3'b101, 3'b101, 3'b000, 3'b000};
    exp  = '{9'b0001_0_0_01_1, 9'b0001_0_0_10_1, 9'b0001_0_0_11_1,
             9'b0001_0_0_11_1, 9'b0001_0_0_11_1};
    for (int i = 0; i < 3; i++) begin
      step(stim[i]);
      n_checks++;
      if (obs() !== exp[i])
        $display("FAIL pre_reset[%0d] got=%b exp=%b", i, obs(), exp[i]);
      else n_passed++;
    end
    // Asynchronous: outputs must clear before any clock edge.
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (obs() !== 9'b0000_0_0_00_0)
      $display("FAIL async_reset got=%b exp=%b", obs(), 9'b0000_0_0_00_0);
    else n_passed++;
    @(posedge clk);
    #1;
    n_checks++;
    if (obs() !== 9'b0000_0_0_00_0)
      $display("FAIL reset_hold got=%b exp=%b", obs(), 9'b0000_0_0_00_0);
    else n_passed++;
    @(negedge clk);
    rst = 1'b0;
    // Clean frame 0,1,0,0 (one '1' -> parity 0) after reset.
    stim = '{3'b110, 3'b101, 3'b100, 3'b100, 3'b100};
    exp  = '{9'b0000_0_0_01_1, 9'b0000_0_0_10_1, 9'b0000_0_0_11_1,
             9'b0000_0_0_00_1, 9'b0010_1_0_00_0};
    for (int i = 0; i < 5; i++) begin
      step(stim[i]);
      n_checks++;
      if (obs() !== exp[i])
        $display("FAIL post_reset[%0d] got=%b exp=%b", i, obs(), exp[i]);
      else n_passed++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_passed = 0;
    test_reset();
    test_good_frame();
    test_bad_parity();
    test_en_gap();
    test_premature_sync();
    test_idle_ignore();
    test_back_to_back();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
